// File: rtl/mem_sync_sp_arb.sv
// Two-port arbiter/sequencer in front of a single-port synchronous SRAM: A is read-only, B is load/store.
// Optional performance counters are enabled by defining MEM_ARB_PERF_EN.
module mem_sync_sp_arb #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int DATA_BYTES = DATA_WIDTH / 8,
    parameter int MEM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_a_req,
    input  logic [ADDR_WIDTH-1:0] i_a_addr,
    output logic                  o_a_gnt,
    output logic                  o_a_rvalid,
    output logic [DATA_WIDTH-1:0] o_a_rdata,
    input  logic                  i_b_req,
    input  logic [ADDR_WIDTH-1:0] i_b_addr,
    input  logic [DATA_WIDTH-1:0] i_b_wdata,
    input  logic [DATA_BYTES-1:0] i_b_wen,
    output logic                  o_b_gnt,
    output logic                  o_b_rvalid,
    output logic [DATA_WIDTH-1:0] o_b_rdata,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic [DATA_BYTES-1:0] o_mem_wen,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]           o_perf_conflicts,
    output logic [31:0]           o_perf_a_stall
`endif
);

    logic                  last_b;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [MEM_LAT-1:0]    tag_valid;
    logic [MEM_LAT-1:0]    tag_port;
    logic [MEM_LAT-1:0]    tag_write;
    logic                  any_gnt;
    logic                  b_is_write;
    logic                  resp_valid;
    logic                  resp_port;
    logic                  resp_write;

    // Round-robin only matters on conflict; a lone requester always wins.
    always_comb begin
        o_a_gnt = 1'b0;
        o_b_gnt = 1'b0;
        if (rst_n) begin
            if (i_a_req && i_b_req) begin
                o_a_gnt = last_b;
                o_b_gnt = !last_b;
            end else begin
                o_a_gnt = i_a_req;
                o_b_gnt = i_b_req;
            end
        end
    end

    assign any_gnt    = o_a_gnt || o_b_gnt;
    assign b_is_write = |i_b_wen;

    // Idle cycles keep the previous address so the macro sees no toggling and no write.
    always_comb begin
        o_mem_addr  = addr_q;
        o_mem_wdata = '0;
        o_mem_wen   = '0;
        if (o_a_gnt) begin
            o_mem_addr = i_a_addr;
        end else if (o_b_gnt) begin
            o_mem_addr  = i_b_addr;
            o_mem_wdata = i_b_wdata;
            o_mem_wen   = i_b_wen;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b    <= 1'b0;
            addr_q    <= '0;
            tag_valid <= '0;
            tag_port  <= '0;
            tag_write <= '0;
        end else begin
            if (any_gnt) begin
                last_b <= o_b_gnt;
                addr_q <= o_mem_addr;
            end
            for (int i = MEM_LAT - 1; i > 0; i--) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_port[i]  <= tag_port[i-1];
                tag_write[i] <= tag_write[i-1];
            end
            tag_valid[0] <= any_gnt;
            tag_port[0]  <= o_b_gnt;
            tag_write[0] <= o_b_gnt && b_is_write;
        end
    end

    // The oldest tag lines up with the memory's read data for that grant.
    assign resp_valid = tag_valid[MEM_LAT-1];
    assign resp_port  = tag_port[MEM_LAT-1];
    assign resp_write = tag_write[MEM_LAT-1];

    assign o_a_rvalid = resp_valid && !resp_port;
    assign o_b_rvalid = resp_valid && resp_port;
    assign o_a_rdata  = o_a_rvalid ? i_mem_rdata : '0;
    assign o_b_rdata  = (o_b_rvalid && !resp_write) ? i_mem_rdata : '0;

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_perf_conflicts <= '0;
            o_perf_a_stall   <= '0;
        end else begin
            if (i_a_req && i_b_req && (o_perf_conflicts != 32'hFFFF_FFFF)) begin
                o_perf_conflicts <= o_perf_conflicts + 32'd1;
            end
            if (i_a_req && !o_a_gnt && (o_perf_a_stall != 32'hFFFF_FFFF)) begin
                o_perf_a_stall <= o_perf_a_stall + 32'd1;
            end
        end
    end
`endif

endmodule
